// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync, ghost rejection, debounce, key decode.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes every REPEAT_SCANS full scans.
module keypad_scanner #(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic       div_clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

    if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_SCANS must be in 2..15");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_SCANS must be at least 1");
    end

    typedef enum logic [1:0] {PH_DRIVE, PH_SYNC1, PH_SYNC2, PH_SAMPLE} phase_t;

    logic [3:0]  col_s1_q, col_s2_q;
    logic [1:0]  row_sel_q, row_sel_d;
    phase_t      phase_q;
    logic [15:0] map_q, scan_map;
    logic        prev_none_q;
    logic [3:0]  prev_code_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  row_n_q;
    logic        key_valid_q, key_held_q;
    logic [3:0]  key_code_q;

    logic [4:0]  ones;
    logic [3:0]  idx;
    logic        cand_none, cand_same, differs, eval, accept;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    logic [REP_W-1:0] rep_q;
`endif

    always_comb begin
        // The row being sampled this cycle is merged in so evaluation sees the full scan.
        scan_map = map_q;
        scan_map[{row_sel_q, 2'b00} +: 4] = ~col_s2_q;

        ones = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_map[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end
        cand_none = (ones != 5'd1);
        cand_same = (cand_none == prev_none_q) && (cand_none || idx == prev_code_q);

        if (!cand_same)
            cnt_d = 4'd1;
        else if (cnt_q == DB_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 4'd1;

        differs   = cand_none ? key_held_q : (!key_held_q || idx != key_code_q);
        eval      = (row_sel_q == 2'd3) && (phase_q == PH_SAMPLE);
        accept    = eval && (cnt_d == DB_MAX) && differs;
        row_sel_d = (phase_q == PH_SAMPLE) ? row_sel_q + 2'd1 : row_sel_q;
    end

    always_ff @(posedge div_clk) begin
        if (rst) begin
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            row_sel_q   <= 2'd0;
            phase_q     <= PH_DRIVE;
            map_q       <= '0;
            prev_none_q <= 1'b1;
            prev_code_q <= '0;
            cnt_q       <= '0;
            row_n_q     <= 4'hF;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            col_s1_q    <= col_n;
            col_s2_q    <= col_s1_q;
            phase_q     <= phase_t'(phase_q + 2'd1);
            row_sel_q   <= row_sel_d;
            row_n_q     <= ~(4'b0001 << row_sel_d);
            key_valid_q <= 1'b0;

            if (phase_q == PH_SAMPLE)
                map_q <= scan_map;

            if (eval) begin
                prev_none_q <= cand_none;
                prev_code_q <= idx;
                cnt_q       <= cnt_d;
                if (accept) begin
                    key_held_q <= !cand_none;
                    if (!cand_none) begin
                        key_code_q  <= idx;
                        key_valid_q <= 1'b1;
                    end
                end
`ifdef KEYPAD_REPEAT_EN
                // A state change restarts the repeat interval and wins over a due repeat.
                if (accept)
                    rep_q <= '0;
                else if (key_held_q) begin
                    if (rep_q == REP_LAST) begin
                        rep_q       <= '0;
                        key_valid_q <= 1'b1;
                    end else begin
                        rep_q <= rep_q + REP_ONE;
                    end
                end
`endif
            end
        end
    end

    assign row_n     = row_n_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model plus a strobe scoreboard.
module tb_keypad_scanner;

    logic        div_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] pressed = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    keypad_scanner #(
        .DEBOUNCE_SCANS(4),
        .REPEAT_SCANS  (4)
    ) dut (
        .div_clk  (div_clk),
        .rst      (rst),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_held (key_held)
    );

    always #5 div_clk = ~div_clk;

    // Passive matrix: a pressed key shorts its column to a driven-low row.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (row_n[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) col_n[c] = 1'b0;
    end

    task automatic expect_strobe(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // One clock; any strobe seen is matched against the oldest expected one.
    task automatic tick();
        exp_t e;
        @(posedge div_clk);
        cyc++;
        @(negedge div_clk);
        if (key_valid !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL strobe_unexpected: got valid=%b code %0d at cycle %0d, required no strobe",
                         key_valid, key_code, cyc);
            end else begin
                e = exp_q.pop_front();
                if (key_valid !== 1'b1 || key_code !== e.code || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL strobe: got code %0d at cycle %0d, required code %0d at cycle %0d",
                             key_code, cyc, e.code, e.cyc);
                end
            end
        end
    endtask

    task automatic scans(input int n);
        repeat (16 * n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge div_clk);
        @(negedge div_clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        pressed = 16'h0040;
        expect_strobe(4'd6, 64);
        scans(6);
        repeat (5) tick();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (row_n !== 4'b1111) begin n_bad++; $display("FAIL reset_row_n: got %b, required 1111", row_n); end
        n_cmp++;
        if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %b, required 0", key_valid); end
        n_cmp++;
        if (key_code !== 4'd0) begin n_bad++; $display("FAIL reset_key_code: got %0d, required 0", key_code); end
        n_cmp++;
        if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset_key_held: got %b, required 0", key_held); end
        rst = 1'b0;
        cyc = 0;
        tick();
        n_cmp++;
        if (row_n !== 4'b1110) begin n_bad++; $display("FAIL reset_first_row: got %b, required 1110", row_n); end
        // Debounce restarts from scratch after reset.
        expect_strobe(4'd6, 64);
        repeat (79) tick();
        pressed = '0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_missing_strobe: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_single_press();
        do_reset();
        pressed = 16'h0040;
        expect_strobe(4'd6, 64);
        scans(10);
        n_cmp++;
        if (key_held !== 1'b1) begin n_bad++; $display("FAIL single_held: got %b, required 1", key_held); end
        n_cmp++;
        if (key_code !== 4'd6) begin n_bad++; $display("FAIL single_code: got %0d, required 6", key_code); end
        pressed = '0;
        scans(3);
        n_cmp++;
        if (key_held !== 1'b1) begin n_bad++; $display("FAIL release_early: got held %b, required 1", key_held); end
        scans(1);
        n_cmp++;
        if (key_held !== 1'b0) begin n_bad++; $display("FAIL release_held: got %b, required 0", key_held); end
        n_cmp++;
        if (key_code !== 4'd6) begin n_bad++; $display("FAIL release_code: got %0d, required 6", key_code); end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL single_missing_strobe: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pressed = 16'h0200;
            scans(3);
            pressed = '0;
            scans(1);
            n_cmp++;
            if (key_held !== 1'b0) begin n_bad++; $display("FAIL bounce_held: got %b at burst %0d, required 0", key_held, k); end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bounce_queue: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ghosting();
        do_reset();
        pressed = 16'h8001;
        scans(8);
        n_cmp++;
        if (key_held !== 1'b0) begin n_bad++; $display("FAIL ghost_held: got %b, required 0", key_held); end
        pressed = 16'h0001;
        expect_strobe(4'd0, 192);
        scans(3);
        n_cmp++;
        if (key_held !== 1'b0) begin n_bad++; $display("FAIL ghost_early: got held %b, required 0", key_held); end
        scans(1);
        n_cmp++;
        if (key_held !== 1'b1) begin n_bad++; $display("FAIL ghost_accept_held: got %b, required 1", key_held); end
        n_cmp++;
        if (key_code !== 4'd0) begin n_bad++; $display("FAIL ghost_code: got %0d, required 0", key_code); end
        pressed = '0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ghost_missing_strobe: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_direct_change();
        do_reset();
        pressed = 16'h0008;
        expect_strobe(4'd3, 64);
        scans(5);
        n_cmp++;
        if (key_code !== 4'd3) begin n_bad++; $display("FAIL direct_first_code: got %0d, required 3", key_code); end
        pressed = 16'h1000;
        expect_strobe(4'd12, 144);
        for (int k = 0; k < 5; k++) begin
            scans(1);
            n_cmp++;
            if (key_held !== 1'b1) begin n_bad++; $display("FAIL direct_held: got %b at scan %0d, required 1", key_held, k); end
        end
        n_cmp++;
        if (key_code !== 4'd12) begin n_bad++; $display("FAIL direct_code: got %0d, required 12", key_code); end
        pressed = '0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL direct_missing_strobe: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_repeat();
        do_reset();
        pressed = 16'h0020;
        expect_strobe(4'd5, 64);
`ifdef KEYPAD_REPEAT_EN
        for (int k = 1; k <= 4; k++) expect_strobe(4'd5, 64 + 64 * k);
`endif
        scans(20);
        n_cmp++;
        if (key_held !== 1'b1) begin n_bad++; $display("FAIL repeat_held: got %b, required 1", key_held); end
        // The release lands on the scan where a repeat would be due; no strobe there.
        pressed = '0;
        scans(5);
        n_cmp++;
        if (key_held !== 1'b0) begin n_bad++; $display("FAIL repeat_release: got held %b, required 0", key_held); end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL repeat_missing_strobe: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_ghosting();
        test_direct_change();
        test_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
